// File: rtl/pwm_env_pkg.sv
// ---------------------------------------------------------------------------
// pwm_env_pkg
// Shared definitions for the PWM envelope generator.
//   MODE_*       : per-channel envelope mode encodings (2 bits per channel)
//   clog2_min1() : counter width helper that never returns zero, so a
//                  prescaler of 1 still gets a 1-bit register
// ---------------------------------------------------------------------------
package pwm_env_pkg;

    localparam logic [1:0] MODE_WINDOW = 2'd0;
    localparam logic [1:0] MODE_RAMP   = 2'd1;
    localparam logic [1:0] MODE_TRI    = 2'd2;
    localparam logic [1:0] MODE_CONST  = 2'd3;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pwm_env_channel.sv
// ---------------------------------------------------------------------------
// pwm_env_channel
// One output channel: maps the shared envelope index to a duty value,
// holds it for a whole PWM frame and compares it against the shared count.
//
// Ports
//   i_clk, i_rst      : clock, asynchronous active-high reset
//   i_enable          : channel enable, gates the registered pulse only
//   i_mode            : envelope mode (MODE_WINDOW/RAMP/TRI/CONST)
//   i_level           : duty used by WINDOW and CONST modes
//   i_win_lo/i_win_hi : exclusive window bounds on the index
//   i_index_next      : index value that will be current from the next edge
//   i_load            : duty register load strobe (frame end or restart)
//   i_count           : shared PWM counter
//   o_pulse           : registered PWM output
// ---------------------------------------------------------------------------
module pwm_env_channel
    import pwm_env_pkg::*;
#(
    parameter int PWM_W = 6,
    parameter int IDX_W = 6
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_enable,
    input  logic [1:0]       i_mode,
    input  logic [PWM_W-1:0] i_level,
    input  logic [IDX_W-1:0] i_win_lo,
    input  logic [IDX_W-1:0] i_win_hi,
    input  logic [IDX_W-1:0] i_index_next,
    input  logic             i_load,
    input  logic [PWM_W-1:0] i_count,
    output logic             o_pulse
);

    localparam int FOLD_W = IDX_W - 1;

    logic [PWM_W-1:0]  w_ramp;
    logic [PWM_W-1:0]  w_tri;
    logic [FOLD_W-1:0] w_fold;
    logic              w_in_window;
    logic [PWM_W-1:0]  w_duty_next;

    logic [PWM_W-1:0]  r_duty;
    logic              r_pulse;

    // Ramp: index placed at the top of the duty word, so the envelope
    // always spans the full duty range regardless of relative widths.
    if (IDX_W >= PWM_W) begin : g_ramp_trunc
        assign w_ramp = PWM_W'(i_index_next >> (IDX_W - PWM_W));
    end else begin : g_ramp_widen
        assign w_ramp = PWM_W'(i_index_next) << (PWM_W - IDX_W);
    end

    // Triangle: the upper half of the index counts back down by inverting
    // the low bits, then the folded value is MSB-aligned like the ramp.
    if (FOLD_W >= PWM_W) begin : g_tri_trunc
        assign w_tri = PWM_W'(w_fold >> (FOLD_W - PWM_W));
    end else begin : g_tri_widen
        assign w_tri = PWM_W'(w_fold) << (PWM_W - FOLD_W);
    end

    always_comb begin
        w_fold      = i_index_next[IDX_W-1] ? ~i_index_next[FOLD_W-1:0]
                                            :  i_index_next[FOLD_W-1:0];
        w_in_window = (i_index_next > i_win_lo) && (i_index_next < i_win_hi);
        case (i_mode)
            MODE_WINDOW: w_duty_next = w_in_window ? i_level : '0;
            MODE_RAMP:   w_duty_next = w_ramp;
            MODE_TRI:    w_duty_next = w_tri;
            default:     w_duty_next = i_level;
        endcase
    end

    // Duty only changes on frame boundaries so a frame is never glitched
    // by mid-frame mode/level/window changes.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_duty <= '0;
        end else if (i_load) begin
            r_duty <= w_duty_next;
        end
    end

    // Strict less-than: duty 0 is always low, 100 % is unreachable.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= i_enable & (i_count < r_duty);
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/pwm_envelope_gen.sv
// ---------------------------------------------------------------------------
// pwm_envelope_gen
// Multi-channel PWM envelope generator. One shared timebase (PWM counter,
// frame prescaler, envelope index) feeds N_CH channels so every output stays
// phase-aligned.
//
// Ports
//   sysclk        : system clock, rising edge
//   rst           : asynchronous active-high reset
//   enable[N_CH]  : per-channel output enable
//   mode          : 2 bits per channel, channel c at [2c+1:2c]
//   level         : PWM_W bits per channel, duty for WINDOW/CONST
//   win_lo/win_hi : IDX_W bits per channel, exclusive window bounds
//   sync_restart  : restart the timebase on the next edge
//   pulse[N_CH]   : registered PWM outputs
//   frame_tick    : high during the count==0 cycle of each frame
//   index         : current envelope index
// ---------------------------------------------------------------------------
module pwm_envelope_gen
    import pwm_env_pkg::*;
#(
    parameter int N_CH  = 2,
    parameter int PWM_W = 6,
    parameter int PRE   = 13,
    parameter int IDX_W = 6
) (
    input  logic                    sysclk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         enable,
    input  logic [2*N_CH-1:0]       mode,
    input  logic [PWM_W*N_CH-1:0]   level,
    input  logic [IDX_W*N_CH-1:0]   win_lo,
    input  logic [IDX_W*N_CH-1:0]   win_hi,
    input  logic                    sync_restart,
    output logic [N_CH-1:0]         pulse,
    output logic                    frame_tick,
    output logic [IDX_W-1:0]        index
);

    localparam int PRE_W = clog2_min1(PRE);

    logic [PWM_W-1:0] r_count;
    logic [PRE_W-1:0] r_pre_cnt;
    logic [IDX_W-1:0] r_index;
    logic             r_frame_tick;

    logic             w_frame_end;
    logic             w_pre_wrap;
    logic             w_load;
    logic [IDX_W-1:0] w_index_next;

    always_comb begin
        w_frame_end = &r_count;
        w_pre_wrap  = (r_pre_cnt == PRE_W'(PRE - 1));
        w_load      = w_frame_end | sync_restart;
        // Restart has priority over a coincident frame end.
        if (sync_restart) begin
            w_index_next = '0;
        end else if (w_frame_end && w_pre_wrap) begin
            w_index_next = r_index + 1'b1;
        end else begin
            w_index_next = r_index;
        end
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            r_count      <= '0;
            r_pre_cnt    <= '0;
            r_index      <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            r_index <= w_index_next;
            if (sync_restart) begin
                r_count      <= '0;
                r_pre_cnt    <= '0;
                r_frame_tick <= 1'b0;
            end else begin
                r_count      <= r_count + 1'b1;
                r_frame_tick <= w_frame_end;
                if (w_frame_end) begin
                    r_pre_cnt <= w_pre_wrap ? '0 : r_pre_cnt + 1'b1;
                end
            end
        end
    end

    // Channels see the post-update index so the duty loaded at a frame end
    // already reflects the index that frame will run at.
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        pwm_env_channel #(
            .PWM_W (PWM_W),
            .IDX_W (IDX_W)
        ) u_ch (
            .i_clk        (sysclk),
            .i_rst        (rst),
            .i_enable     (enable[c]),
            .i_mode       (mode[2*c +: 2]),
            .i_level      (level[PWM_W*c +: PWM_W]),
            .i_win_lo     (win_lo[IDX_W*c +: IDX_W]),
            .i_win_hi     (win_hi[IDX_W*c +: IDX_W]),
            .i_index_next (w_index_next),
            .i_load       (w_load),
            .i_count      (r_count),
            .o_pulse      (pulse[c])
        );
    end

    assign frame_tick = r_frame_tick;
    assign index      = r_index;

endmodule

// File: tb/tb_pwm_envelope_gen.sv
// ---------------------------------------------------------------------------
// tb_pwm_envelope_gen
// Bench for pwm_envelope_gen with default parameters (2 ch, 64-cycle frames,
// 13 frames per index step, 64 index steps).
// ---------------------------------------------------------------------------
module tb_pwm_envelope_gen;

    localparam int W = 9;   // {pulse[1:0], frame_tick, index[5:0]}

    // ------------------------------------------------------------ clock/reset
    logic        sysclk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  enable = 2'b11;
    logic [3:0]  mode = '0;
    logic [11:0] level = '0;
    logic [11:0] win_lo = '0;
    logic [11:0] win_hi = '0;
    logic        sync_restart = 1'b0;
    logic [1:0]  pulse;
    logic        frame_tick;
    logic [5:0]  index;

    always #5 sysclk = ~sysclk;

    pwm_envelope_gen dut (
        .sysclk       (sysclk),
        .rst          (rst),
        .enable       (enable),
        .mode         (mode),
        .level        (level),
        .win_lo       (win_lo),
        .win_hi       (win_hi),
        .sync_restart (sync_restart),
        .pulse        (pulse),
        .frame_tick   (frame_tick),
        .index        (index)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ------------------------------------------------------ reference model
    function automatic logic [5:0] exp_duty(input logic [1:0] md, input logic [5:0] lvl,
                                            input logic [5:0] lo, input logic [5:0] hi,
                                            input logic [5:0] idx);
        int v;
        case (md)
            2'd0:    v = (idx > lo && idx < hi) ? int'(lvl) : 0;
            2'd1:    v = int'(idx);
            2'd2:    v = (idx < 6'd32) ? 2 * int'(idx) : 2 * (63 - int'(idx));
            default: v = int'(lvl);
        endcase
        return 6'(v);
    endfunction

    logic [5:0] m_count = '0;
    logic [3:0] m_pre = '0;
    logic [5:0] m_idx = '0;
    logic [5:0] m_duty [2] = '{6'd0, 6'd0};
    logic       m_tick = 1'b0;
    logic [1:0] m_pulse = '0;

    always @(posedge sysclk or posedge rst) begin
        if (rst) begin
            m_count <= '0;
            m_pre   <= '0;
            m_idx   <= '0;
            m_tick  <= 1'b0;
            m_pulse <= '0;
            for (int c = 0; c < 2; c++) m_duty[c] <= '0;
        end else begin
            for (int c = 0; c < 2; c++) m_pulse[c] <= enable[c] && (m_count < m_duty[c]);
            if (sync_restart) begin
                m_count <= '0;
                m_pre   <= '0;
                m_idx   <= '0;
                m_tick  <= 1'b0;
                for (int c = 0; c < 2; c++)
                    m_duty[c] <= exp_duty(mode[2*c +: 2], level[6*c +: 6], win_lo[6*c +: 6],
                                          win_hi[6*c +: 6], 6'd0);
            end else begin
                m_count <= m_count + 6'd1;
                m_tick  <= (m_count == 6'd63);
                if (m_count == 6'd63) begin
                    if (m_pre == 4'd12) begin
                        m_pre <= '0;
                        m_idx <= m_idx + 6'd1;
                        for (int c = 0; c < 2; c++)
                            m_duty[c] <= exp_duty(mode[2*c +: 2], level[6*c +: 6], win_lo[6*c +: 6],
                                                  win_hi[6*c +: 6], m_idx + 6'd1);
                    end else begin
                        m_pre <= m_pre + 4'd1;
                        for (int c = 0; c < 2; c++)
                            m_duty[c] <= exp_duty(mode[2*c +: 2], level[6*c +: 6], win_lo[6*c +: 6],
                                                  win_hi[6*c +: 6], m_idx);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------ scoreboard
    logic [W-1:0] exp_q[$];
    int err_p0 = 0;
    int err_p1 = 0;
    int err_t  = 0;
    int err_i  = 0;

    always @(posedge sysclk) begin
        #1;
        exp_q.push_back({m_pulse, m_tick, m_idx});
    end

    always @(negedge sysclk) begin
        logic [W-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (pulse[0] !== e[7]) err_p0++;
            if (pulse[1] !== e[8]) err_p1++;
            if (frame_tick !== e[6]) err_t++;
            if (index !== e[5:0]) err_i++;
            if (m_count == 6'd63) begin
                check("sb frame pulse0 bad cycles", err_p0, 0);
                check("sb frame pulse1 bad cycles", err_p1, 0);
                check("sb frame tick bad cycles", err_t, 0);
                check("sb frame index bad cycles", err_i, 0);
                err_p0 = 0;
                err_p1 = 0;
                err_t  = 0;
                err_i  = 0;
            end
        end
    end

    // --------------------------------------------------------- driver tasks
    task automatic set_ch(input int c, input logic [1:0] md, input logic [5:0] lvl,
                          input logic [5:0] lo, input logic [5:0] hi);
        mode[2*c +: 2]   = md;
        level[6*c +: 6]  = lvl;
        win_lo[6*c +: 6] = lo;
        win_hi[6*c +: 6] = hi;
    endtask

    task automatic wait_tick(input string name);
        int n = 0;
        do begin
            @(negedge sysclk);
            n++;
        end while (!frame_tick && n < 200);
        check(name, int'(frame_tick), 1);
    endtask

    task automatic wait_index(input logic [5:0] target, input int budget);
        int n = 0;
        while (index !== target && n < budget) begin
            @(negedge sysclk);
            n++;
        end
        check("index reached", int'(index), int'(target));
    endtask

    // Waits for the next frame_tick, then counts high cycles over the 64
    // cycles of that frame. Optional actions at a given count offset.
    task automatic measure_frame(input int dis_at, input int en_at, input int lvl_at,
                                 input logic [5:0] new_lvl,
                                 output int hi0, output int hi1, output int first1);
        hi0 = 0;
        hi1 = 0;
        first1 = -1;
        wait_tick("frame tick seen");
        for (int k = 0; k < 64; k++) begin
            if (pulse[0]) hi0++;
            if (pulse[1]) begin
                hi1++;
                if (first1 < 0) first1 = k;
            end
            if (k == dis_at) enable[0] = 1'b0;
            if (k == en_at)  enable[0] = 1'b1;
            if (k == lvl_at) level[11:6] = new_lvl;
            if (k < 63) @(negedge sysclk);
        end
    endtask

    typedef struct {
        logic [5:0] idx;
        logic [1:0] md;
        logic [5:0] lvl;
        logic [5:0] lo;
        logic [5:0] hi;
        int         exp0;
        int         exp1;
    } row_t;

    row_t rows[10];

    // ------------------------------------------------------------ main test
    initial begin
        int h0, h1, f1, n, hi;

        rows[0] = '{6'd5,  2'd3, 6'd16, 6'd0,  6'd0,  0,  16};
        rows[1] = '{6'd10, 2'd1, 6'd0,  6'd0,  6'd0,  0,  10};
        rows[2] = '{6'd15, 2'd0, 6'd7,  6'd14, 6'd16, 0,  7};
        rows[3] = '{6'd16, 2'd2, 6'd0,  6'd0,  6'd0,  63, 32};
        rows[4] = '{6'd33, 2'd2, 6'd0,  6'd0,  6'd0,  63, 60};
        rows[5] = '{6'd40, 2'd1, 6'd0,  6'd0,  6'd0,  63, 40};
        rows[6] = '{6'd47, 2'd0, 6'd50, 6'd46, 6'd47, 63, 0};
        rows[7] = '{6'd48, 2'd3, 6'd0,  6'd0,  6'd0,  0,  0};
        rows[8] = '{6'd50, 2'd3, 6'd63, 6'd0,  6'd0,  0,  63};
        rows[9] = '{6'd63, 2'd2, 6'd0,  6'd0,  6'd0,  0,  0};

        set_ch(0, 2'd0, 6'd63, 6'd15, 6'd48);
        set_ch(1, 2'd3, 6'd16, 6'd0, 6'd0);
        repeat (3) @(negedge sysclk);
        check("reset pulse", int'(pulse), 0);
        check("reset frame_tick", int'(frame_tick), 0);
        check("reset index", int'(index), 0);
        rst = 1'b0;

        n = 0;
        do begin
            @(negedge sysclk);
            n++;
        end while (!frame_tick && n < 200);
        check("first tick after reset", n, 64);

        // CONST 16, level moved to 40 at count 20: this frame 16, next 40
        measure_frame(-1, -1, 20, 6'd40, h0, h1, f1);
        check("const16 hi1", h1, 16);
        check("const16 first high", f1, 1);
        check("window idx0 hi0", h0, 0);
        measure_frame(-1, -1, -1, 6'd0, h0, h1, f1);
        check("const40 hi1", h1, 40);

        // Reset in the middle of a frame at index 5
        set_ch(1, 2'd3, 6'd63, 6'd0, 6'd0);
        wait_index(6'd5, 5000);
        measure_frame(-1, -1, -1, 6'd0, h0, h1, f1);
        check("const63 hi1", h1, 63);
        wait_tick("pre-reset tick");
        repeat (37) @(negedge sysclk);
        check("pre-reset pulse1", int'(pulse[1]), 1);
        check("pre-reset index", int'(index), 5);
        #1 rst = 1'b1;
        #1;
        check("async reset pulse", int'(pulse), 0);
        check("async reset frame_tick", int'(frame_tick), 0);
        check("async reset index", int'(index), 0);
        @(negedge sysclk);
        @(negedge sysclk);
        rst = 1'b0;
        n = 0;
        hi = 0;
        do begin
            @(negedge sysclk);
            n++;
            if (pulse != 2'b00) hi++;
        end while (!frame_tick && n < 200);
        check("tick after mid-frame reset", n, 64);
        check("no partial pulse after reset", hi, 0);

        // Envelope sweep with table-driven channel 1 settings
        for (int r = 0; r < 10; r++) begin
            if (rows[r].idx == 6'd33) begin
                wait_index(6'd20, 60000);
                measure_frame(5, 30, -1, 6'd0, h0, h1, f1);
                check("enable toggle hi0", h0, 38);
                check("enable toggle hi1", h1, 40);
                enable = 2'b00;
                wait_index(6'd21, 1000);
                measure_frame(-1, -1, -1, 6'd0, h0, h1, f1);
                check("disabled hi0", h0, 0);
                check("disabled hi1", h1, 0);
                enable = 2'b11;
            end
            wait_index(rows[r].idx, 60000);
            set_ch(1, rows[r].md, rows[r].lvl, rows[r].lo, rows[r].hi);
            measure_frame(-1, -1, -1, 6'd0, h0, h1, f1);
            check($sformatf("row idx%0d hi0", rows[r].idx), h0, rows[r].exp0);
            check($sformatf("row idx%0d hi1", rows[r].idx), h1, rows[r].exp1);
        end

        // Wrap to 0, then restart coincident with the pre_cnt==12 frame end
        wait_index(6'd0, 2000);
        set_ch(1, 2'd1, 6'd0, 6'd0, 6'd0);
        repeat (12) wait_tick("tick before restart");
        repeat (63) @(negedge sysclk);
        sync_restart = 1'b1;
        @(negedge sysclk);
        sync_restart = 1'b0;
        check("restart frame_tick", int'(frame_tick), 0);
        check("restart index", int'(index), 0);
        hi = 0;
        for (int k = 0; k < 64; k++) begin
            if (pulse[1]) hi++;
            @(negedge sysclk);
        end
        check("restart ramp hi1", hi, 0);
        check("tick after restart frame", int'(frame_tick), 1);
        check("index after restart frame", int'(index), 0);

        check("sb tail bad cycles", err_p0 + err_p1 + err_t + err_i, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
